// File: rtl/cs_accumulator.sv
// Carry-save resolving group accumulator with a valid/ready result port.
// Optional saturation on signed overflow: define CS_ACCUMULATOR_SAT_EN (default build wraps).
//
// state | meaning
// IDLE  | waiting for the first beat of a group
// ACC   | group in progress, cnt_q beats of len_q accepted
// DONE  | group sum presented on out_o, waiting for ready_i
module cs_accumulator #(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int ACC_SIZE  = 32,
    parameter int LEN_SIZE  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [IN_SIZE_0+IN_SIZE_1+4-1:0]   in_i [0:1],
    input  logic [LEN_SIZE-1:0]                len_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [ACC_SIZE-1:0]                out_o,
    output logic                               overflow_o
);

    localparam int W = IN_SIZE_0 + IN_SIZE_1 + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_SIZE-1:0] acc_q, acc_d;
    logic [ACC_SIZE-1:0] out_q, out_d;
    logic [LEN_SIZE-1:0] cnt_q, cnt_d;
    logic [LEN_SIZE-1:0] len_q, len_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;

    logic [W-1:0]        r;
    logic [ACC_SIZE-1:0] r_ext;
    logic [ACC_SIZE-1:0] sum;
    logic [ACC_SIZE-1:0] acc_next;
    logic [LEN_SIZE-1:0] len_eff;
    logic [LEN_SIZE-1:0] cnt_inc;
    logic                add_ovf;
    logic                accept;

    assign ready_o    = (state_q != DONE) || ready_i;
    assign accept     = valid_i && ready_o;
    assign valid_o    = valid_q;
    assign out_o      = out_q;
    assign overflow_o = ovf_q;

    // Resolve the carry-save pair modulo 2^W, then sign-extend to the accumulator width.
    always_comb begin
        r       = in_i[0] + in_i[1];
        r_ext   = ACC_SIZE'($signed(r));
        sum     = acc_q + r_ext;
        add_ovf = (acc_q[ACC_SIZE-1] == r_ext[ACC_SIZE-1]) &&
                  (sum[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);
        len_eff = (len_i == '0) ? LEN_SIZE'(1) : len_i;
        cnt_inc = cnt_q + LEN_SIZE'(1);
    end

`ifdef CS_ACCUMULATOR_SAT_EN
    localparam logic [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

    // Overflow direction follows the sign of the operands (both share it on overflow).
    always_comb begin
        acc_next = sum;
        if (add_ovf) begin
            acc_next = acc_q[ACC_SIZE-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        acc_next = sum;
    end
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && ready_i) begin
                    valid_d = 1'b0;
                    if (!valid_i) begin
                        state_d = IDLE;
                    end
                end
                if (accept) begin
                    acc_d = r_ext;
                    cnt_d = LEN_SIZE'(1);
                    len_d = len_eff;
                    ovf_d = 1'b0;
                    if (len_eff == LEN_SIZE'(1)) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        out_d   = r_ext;
                    end else begin
                        state_d = ACC;
                        valid_d = 1'b0;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q || add_ovf;
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        out_d   = acc_next;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_cs_accumulator.sv
// Bench for cs_accumulator: a 32-bit and a 20-bit accumulator driven by the same stimulus.
module tb_cs_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_i;
    logic [15:0] in_i [0:1];
    logic [7:0]  len_i;

    logic        ready_a, valid_a, ovf_a;
    logic [31:0] out_a;
    logic        ready_b, valid_b, ovf_b;
    logic [19:0] out_b;

    int checks = 0;
    int errors = 0;

    bit     mon_en = 1'b0;
    longint got_a[$], got_b[$], exp_a[$], exp_b[$];
    bit     gov_a[$], gov_b[$], eov_a[$], eov_b[$];

    always #5 clk = ~clk;

    cs_accumulator dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_a),
        .in_i(in_i), .len_i(len_i), .valid_o(valid_a), .ready_i(ready_i),
        .out_o(out_a), .overflow_o(ovf_a)
    );

    cs_accumulator #(.ACC_SIZE(20)) dut20 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_b),
        .in_i(in_i), .len_i(len_i), .valid_o(valid_b), .ready_i(ready_i),
        .out_o(out_b), .overflow_o(ovf_b)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_a && ready_i) begin
                got_a.push_back(longint'($signed(out_a)));
                gov_a.push_back(ovf_a);
            end
            if (valid_b && ready_i) begin
                got_b.push_back(longint'($signed(out_b)));
                gov_b.push_back(ovf_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Split a resolved value into a random carry-save pair.
    task automatic set_in(input int r);
        logic [15:0] a;
        a = 16'($urandom);
        in_i[0] = a;
        in_i[1] = 16'(r) - a;
    endtask

    // Group sum from plain integer arithmetic, with wrap or clamp at n bits.
    function automatic void model(input int beats[$], input int n, output longint res, output bit ovf);
        longint mx, mn, acc, s;
        mx  = (64'sd1 <<< (n - 1)) - 1;
        mn  = -mx - 1;
        acc = beats[0];
        ovf = 1'b0;
        for (int i = 1; i < beats.size(); i++) begin
            s = acc + beats[i];
            if (s > mx || s < mn) begin
                ovf = 1'b1;
`ifdef CS_ACCUMULATOR_SAT_EN
                s = (s > mx) ? mx : mn;
`else
                s = s & ((64'sd1 <<< n) - 1);
                if (s > mx) s = s - (64'sd1 <<< n);
`endif
            end
            acc = s;
        end
        res = acc;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; len_i = 8'd0;
        in_i[0] = 16'h0; in_i[1] = 16'h0;
        step(); step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        checks++; if (out_a !== 32'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        valid_i = 1'b1; len_i = 8'd1; ready_i = 1'b1;
        in_i[0] = 16'hFFF0; in_i[1] = 16'h0013;
        step();
        valid_i = 1'b0;
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid_a); end
        checks++; if (out_a !== 32'd3) begin errors++; $display("FAIL single_out: got %0d expected 3", out_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b expected 0", ovf_a); end
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL single_release: got %b expected 0", valid_a); end
    endtask

    task automatic run_group4(input int gap, input int exp_cyc, input string name);
        int beats[4] = '{3, -5, 10, 7};
        int i = 0;
        int cyc = 0;
        int g = gap;
        ready_i = 1'b1;
        while (!valid_a && cyc < 50) begin
            if (i == 2 && g > 0) begin
                valid_i = 1'b0;
                g--;
            end else begin
                valid_i = 1'b1;
                len_i = (i == 0) ? 8'd4 : 8'($urandom_range(0, 255));
                set_in(beats[i]);
                i++;
            end
            step();
            cyc++;
        end
        valid_i = 1'b0;
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc, exp_cyc); end
        checks++; if (out_a !== 32'd15) begin errors++; $display("FAIL %s_out: got %0d expected 15", name, $signed(out_a)); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL %s_ovf: got %b expected 0", name, ovf_a); end
        step();
    endtask

    task automatic test_group4();
        run_group4(0, 4, "group4");
        run_group4(2, 6, "group4_gap");
    endtask

    task automatic test_saturate();
        int cyc = 0;
        logic [19:0] exp20;
`ifdef CS_ACCUMULATOR_SAT_EN
        exp20 = 20'd524287;
`else
        exp20 = 20'(-393236);
`endif
        ready_i = 1'b1; valid_i = 1'b1; len_i = 8'd20;
        while (!valid_b && cyc < 50) begin
            set_in(32767);
            step();
            cyc++;
        end
        valid_i = 1'b0;
        checks++; if (cyc !== 20) begin errors++; $display("FAIL sat_latency: got %0d cycles expected 20", cyc); end
        checks++; if (out_b !== exp20) begin errors++; $display("FAIL sat_out20: got %0d expected %0d", $signed(out_b), $signed(exp20)); end
        checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL sat_ovf20: got %b expected 1", ovf_b); end
        checks++; if (out_a !== 32'd655340) begin errors++; $display("FAIL sat_out32: got %0d expected 655340", $signed(out_a)); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL sat_ovf32: got %b expected 0", ovf_a); end
        step();
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0; valid_i = 1'b1; len_i = 8'd1;
        set_in(4);
        step();
        for (int k = 0; k < 3; k++) begin
            set_in(100 + k);
            #1;
            checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", k, ready_a); end
            checks++; if (valid_a !== 1'b1 || out_a !== 32'd4) begin
                errors++; $display("FAIL stall_hold%0d: got valid %b out %0d expected valid 1 out 4", k, valid_a, out_a);
            end
            step();
        end
        ready_i = 1'b1; len_i = 8'd1;
        set_in(9);
        #1;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL handoff_ready: got %b expected 1", ready_a); end
        step();
        valid_i = 1'b0;
        checks++; if (valid_a !== 1'b1 || out_a !== 32'd9) begin
            errors++; $display("FAIL handoff_out: got valid %b out %0d expected valid 1 out 9", valid_a, out_a);
        end
        step();
    endtask

    task automatic test_reset_midgroup();
        ready_i = 1'b1; valid_i = 1'b1; len_i = 8'd4;
        set_in(11); step();
        set_in(12); step();
        valid_i = 1'b0; rst_n = 1'b0;
        step();
        checks++; if (valid_a !== 1'b0 || out_a !== 32'd0 || ovf_a !== 1'b0 || ready_a !== 1'b1) begin
            errors++; $display("FAIL midreset_outputs: got valid %b out %0d ovf %b ready %b expected 0 0 0 1", valid_a, out_a, ovf_a, ready_a);
        end
        rst_n = 1'b1; valid_i = 1'b1; len_i = 8'd0;
        set_in(5);
        step();
        valid_i = 1'b0;
        checks++; if (valid_a !== 1'b1 || out_a !== 32'd5) begin
            errors++; $display("FAIL len0_out: got valid %b out %0d expected valid 1 out 5", valid_a, out_a);
        end
        step();
    endtask

    task automatic test_random();
        int beats[$];
        int L, eff, gap, tmo;
        bit acc_ok, ov;
        longint res;
        got_a.delete(); got_b.delete(); gov_a.delete(); gov_b.delete();
        exp_a.delete(); exp_b.delete(); eov_a.delete(); eov_b.delete();
        mon_en = 1'b1;
        for (int g = 0; g < 40; g++) begin
            L = $urandom_range(0, 24);
            eff = (L == 0) ? 1 : L;
            beats.delete();
            for (int k = 0; k < eff; k++) begin
                if ($urandom_range(0, 1) == 0)
                    beats.push_back(($urandom_range(0, 1) == 0) ? 32767 : -32768);
                else
                    beats.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            model(beats, 32, res, ov); exp_a.push_back(res); eov_a.push_back(ov);
            model(beats, 20, res, ov); exp_b.push_back(res); eov_b.push_back(ov);
            for (int k = 0; k < eff; k++) begin
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                repeat (gap) begin
                    valid_i = 1'b0;
                    ready_i = ($urandom_range(0, 3) != 0);
                    step();
                end
                valid_i = 1'b1;
                len_i = (k == 0) ? 8'(L) : 8'($urandom_range(0, 255));
                set_in(beats[k]);
                acc_ok = 1'b0;
                tmo = 0;
                while (!acc_ok && tmo < 100) begin
                    ready_i = ($urandom_range(0, 3) != 0);
                    #1;
                    acc_ok = ready_a;
                    step();
                    tmo++;
                end
                if (!acc_ok) begin
                    checks++; errors++;
                    $display("FAIL random_accept_timeout: group %0d beat %0d not accepted within 100 cycles", g, k);
                end
            end
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (5) step();
        mon_en = 1'b0;
        checks++; if (got_a.size() !== exp_a.size() || got_b.size() !== exp_b.size()) begin
            errors++; $display("FAIL random_count: got %0d/%0d results expected %0d/%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++; if (got_a[i] !== exp_a[i] || gov_a[i] !== eov_a[i]) begin
                errors++; $display("FAIL random32_g%0d: got %0d ovf %b expected %0d ovf %b", i, got_a[i], gov_a[i], exp_a[i], eov_a[i]);
            end
        end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++; if (got_b[i] !== exp_b[i] || gov_b[i] !== eov_b[i]) begin
                errors++; $display("FAIL random20_g%0d: got %0d ovf %b expected %0d ovf %b", i, got_b[i], gov_b[i], exp_b[i], eov_b[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_group4();
        test_saturate();
        test_back_to_back();
        test_reset_midgroup();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
